// File: rtl/confidence_pkg.sv
// Shared constants and FSM encoding for the confidence averaging window.
package confidence_pkg;
   localparam int WIN_LOG2       = 4;
   localparam int SCORE_W        = 7;
   localparam int SCORE_IN_MAX   = 100;
   localparam int SCORE_DISP_MAX = 99;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_UPDATE = 2'd1,
      S_OUTPUT = 2'd2
   } state_t;
endpackage

// File: rtl/window_regfile.sv
// Sample store for the window: one write port, one asynchronous read port, no reset.
module window_regfile #(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 7
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);
   logic [DATA_W-1:0] mem [(1<<ADDR_W)];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];
endmodule

// File: rtl/confidence_window.sv
// Running average of the last 2**WIN_LOG2 confidence samples, clamped for a two-digit display.
module confidence_window
   import confidence_pkg::*;
#(
   parameter int WIN_LOG2 = confidence_pkg::WIN_LOG2,
   parameter int SCORE_W  = confidence_pkg::SCORE_W
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               clear,
   input  logic               sample_valid,
   input  logic [SCORE_W-1:0] sample_data,
   output logic               sample_ready,
   output logic [SCORE_W-1:0] confidence_score,
   output logic               score_valid,
   output logic               window_full
);
   localparam int DEPTH = 1 << WIN_LOG2;
   localparam int SUM_W = SCORE_W + WIN_LOG2;
   localparam int CNT_W = WIN_LOG2 + 1;

   state_t              state;
   logic [SCORE_W-1:0]  hold;
   logic [SCORE_W-1:0]  rd_data;
   logic [SCORE_W-1:0]  evicted;
   logic [SCORE_W-1:0]  clamped;
   logic [SCORE_W-1:0]  score_c;
   logic [WIN_LOG2-1:0] wr_ptr;
   logic [CNT_W-1:0]    count;
   logic [SUM_W-1:0]    sum;
   logic [SUM_W-1:0]    avg;
   logic                full_c;
   logic                wr_en;

   assign sample_ready = (state == S_IDLE);
   assign full_c       = (count == CNT_W'(DEPTH));
   // Slots are only read once the window has wrapped, so unreset contents never leak.
   assign evicted      = full_c ? rd_data : '0;
   assign clamped      = (sample_data > SCORE_W'(SCORE_IN_MAX)) ? SCORE_W'(SCORE_IN_MAX) : sample_data;
   assign avg          = sum >> WIN_LOG2;
   assign score_c      = (avg > SUM_W'(SCORE_DISP_MAX)) ? SCORE_W'(SCORE_DISP_MAX) : avg[SCORE_W-1:0];
   assign wr_en        = (state == S_UPDATE) && !clear;

   window_regfile #(.ADDR_W(WIN_LOG2), .DATA_W(SCORE_W)) u_regfile (
      .clk   (clk),
      .we    (wr_en),
      .waddr (wr_ptr),
      .wdata (hold),
      .raddr (wr_ptr),
      .rdata (rd_data)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state            <= S_IDLE;
         hold             <= '0;
         sum              <= '0;
         count            <= '0;
         wr_ptr           <= '0;
         confidence_score <= '0;
         score_valid      <= 1'b0;
         window_full      <= 1'b0;
      end else if (clear) begin
         state            <= S_IDLE;
         sum              <= '0;
         count            <= '0;
         wr_ptr           <= '0;
         confidence_score <= '0;
         score_valid      <= 1'b0;
         window_full      <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (sample_valid) begin
                  hold  <= clamped;
                  state <= S_UPDATE;
               end
            end
            S_UPDATE: begin
               sum         <= sum - SUM_W'(evicted) + SUM_W'(hold);
               wr_ptr      <= wr_ptr + 1'b1;
               count       <= full_c ? count : count + 1'b1;
               window_full <= full_c || (count == CNT_W'(DEPTH - 1));
               state       <= S_OUTPUT;
            end
            S_OUTPUT: begin
               if (full_c) begin
                  confidence_score <= score_c;
                  score_valid      <= 1'b1;
               end
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule
